// File: rtl/arith_pkg.sv
// arith_pkg: shared constants and types for the multi-cycle arithmetic units
//   DIV_WIDTH   default divider operand width
//   div_state_t divider control states
//   count_w()   bits needed to hold an iteration count of 0..w
//   COUNT_W     iteration counter width at the default operand width
package arith_pkg;
    localparam int DIV_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
    function automatic int count_w(input int w);
        return $clog2(w + 1);
    endfunction
    localparam int COUNT_W = count_w(DIV_WIDTH);
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, trial subtract)
//   rem      in  WIDTH+1  current partial remainder
//   quo_msb  in  1        next dividend bit to shift into the remainder
//   divisor  in  WIDTH    divisor
//   rem_next out WIDTH+1  partial remainder after this iteration
//   q_bit    out 1        quotient bit produced by this iteration
module div_step import arith_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted, trial;
    assign shifted  = {rem[WIDTH-1:0], quo_msb};
    assign trial    = shifted - {1'b0, divisor};
    // A set rem MSB means the true shifted value exceeds WIDTH+1 bits, so the divisor always fits.
    assign q_bit    = ~trial[WIDTH] | rem[WIDTH];
    assign rem_next = q_bit ? trial : shifted;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock
//   clk          in  1      rising-edge clock
//   reset        in  1      asynchronous active-high reset
//   start        in  1      request, sampled only in IDLE or DONE
//   A, B         in  WIDTH  dividend / divisor, captured on an accepted start
//   busy         out 1      high while running
//   done         out 1      one-cycle pulse when Q/R/div_by_zero are updated
//   Q, R         out WIDTH  quotient / remainder, held until the next completion
//   div_by_zero  out 1      captured divisor was zero, held with Q/R
module seq_divider import arith_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);
    localparam int CW = count_w(WIDTH);
    div_state_t       state;
    logic [WIDTH:0]   rem, rem_next;
    logic [WIDTH-1:0] quo, quo_next, divisor;
    logic [CW-1:0]    count;
    logic             q_bit;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo_msb  (quo[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );
    assign quo_next = {quo[WIDTH-2:0], q_bit};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            count       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        divisor <= B;
                        quo     <= A;
                        rem     <= '0;
                        count   <= CW'(WIDTH);
                        state   <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (divisor == '0) begin
                        // quo still holds the untouched dividend here
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        Q           <= '1;
                        R           <= quo;
                        div_by_zero <= 1'b1;
                    end else begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            Q           <= quo_next;
                            R           <= rem_next[WIDTH-1:0];
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider against an arithmetic reference model
module tb_seq_divider;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
    } exp_t;
    logic        clk = 0, reset = 1, start = 0;
    logic [31:0] A = 0, B = 0;
    logic        busy, done, div_by_zero;
    logic [31:0] Q, R;
    int          total = 0, passed = 0, cyc = 0;
    exp_t        sb[$];
    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int c);
        exp_t e;
        e.z   = (b == 0);
        e.q   = e.z ? 32'hFFFF_FFFF : a / b;
        e.r   = e.z ? a : a % b;
        e.cyc = c + (e.z ? 1 : 32);
        return e;
    endfunction
    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("Q", Q, e.q);
                chk("R", R, e.r);
                chk("div_by_zero", div_by_zero, e.z);
                chk("latency", cyc, e.cyc);
            end
        end
    end
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        A = a; B = b; start = 1;
        @(posedge clk); #1;
        start = 0;
        sb.push_back(model(a, b, cyc));
    endtask
    task automatic wait_done(input int exp_busy);
        int  n = 0;
        bit  seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) n++;
        end
        chk("done_seen", seen, 1);
        chk("busy_cycles", n, exp_busy);
    endtask
    task automatic op(input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        wait_done(b == 0 ? 1 : 32);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_Q", Q, 0);
        chk("rst_R", R, 0);
        chk("rst_dbz", div_by_zero, 0);
        reset = 0;
        @(negedge clk);
        op(100, 7);
        op(32'hFFFF_FFFF, 32'h8000_0001);
        op(32'hFFFF_FFFF, 1);
        op(5, 0);
        op(9, 3);
        // start held with other operands during RUN must be ignored
        issue(3, 10);
        A = 77; B = 5; start = 1;
        repeat (10) @(negedge clk);
        start = 0;
        wait_done(32 - 10);
        @(negedge clk);
        // back-to-back: accept a new op in the DONE cycle
        issue(32'hFFFF_FFFF, 1);
        wait_done(32);
        issue(1000, 33);
        @(negedge clk);
        chk("b2b_busy", busy, 1);
        chk("b2b_hold_Q", Q, 32'hFFFF_FFFF);
        chk("b2b_hold_R", R, 0);
        wait_done(31);
        repeat (3) @(negedge clk);
        chk("idle_hold_Q", Q, 30);
        chk("idle_hold_R", R, 10);
        // asynchronous abort mid-run
        issue(50, 6);
        repeat (10) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_Q", Q, 0);
        chk("abort_R", R, 0);
        chk("abort_dbz", div_by_zero, 0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        op(50, 6);
        op(0, 17);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 0;
                1: b = $urandom_range(1, 255);
                2: b = a + $urandom_range(0, 1);
                default: b = $urandom;
            endcase
            op(a, b);
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
